// File: rtl/nios2mypio_seq_pkg.sv
// Shared constants for the PIO pattern sequencer: register map, control/status
// bit positions, FSM state encoding and the minimum step interval.
package nios2mypio_seq_pkg;

  localparam logic [3:0] AddrControl = 4'd0;
  localparam logic [3:0] AddrStatus  = 4'd1;
  localparam logic [3:0] AddrPeriod  = 4'd2;
  localparam logic [3:0] AddrLength  = 4'd3;
  localparam logic [3:0] AddrDirect  = 4'd4;
  localparam logic [3:0] AddrPattern = 4'd8;

  localparam int unsigned CtlRunBit  = 0;
  localparam int unsigned CtlLoopBit = 1;

  localparam int unsigned StatRunBit  = 0;
  localparam int unsigned StatPendBit = 1;
  localparam int unsigned StatIdxLsb  = 8;

  // Two cycles is the shortest step; it guarantees a free slot for a deferred direct write.
  localparam int unsigned MinInterval = 2;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } seq_state_e;

  function automatic logic [31:0] clamp_len(input logic [31:0] value, input int unsigned depth);
    return (value > depth) ? depth : value;
  endfunction

endpackage

// File: rtl/nios2mypio_seq_timer.sv
// Step-interval down-counter: clears to zero on start, reloads max(period, 2) - 1
// on each sequencer strobe and otherwise counts down to zero and holds.
module nios2mypio_seq_timer
  import nios2mypio_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             reload,
  input  logic             step,
  input  logic [DIV_W-1:0] period,
  output logic             zero
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic [DIV_W-1:0] reload_val;

  always_comb begin
    if (period < DIV_W'(MinInterval)) begin
      reload_val = DIV_W'(MinInterval - 1);
    end else begin
      reload_val = period - DIV_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (reload) begin
      count_d = reload_val;
    end else if (step && (count_q != '0)) begin
      count_d = count_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/nios2mypio_pio_seq.sv
// Pattern sequencer and write arbiter in front of the 7-bit output PIO: register
// file, pattern table, run FSM and the sequencer-over-direct arbitration.
module nios2mypio_pio_seq
  import nios2mypio_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 7,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DIV_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  ctl_address,
  input  logic        ctl_chipselect,
  input  logic        ctl_write_n,
  input  logic [31:0] ctl_writedata,
  output logic [31:0] ctl_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        busy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LenW = IdxW + 1;

  seq_state_e        state_q;
  logic [IdxW-1:0]   idx_q;
  logic              loop_q;
  logic [DIV_W-1:0]  period_q;
  logic [LenW-1:0]   length_q;
  logic [DATA_W-1:0] pattern_q [DEPTH];
  logic [DATA_W-1:0] direct_buf_q;
  logic              direct_pend_q;
  logic              pio_cs_q;
  logic [DATA_W-1:0] pio_data_q;
  logic              busy_q;

  logic              ctl_wr;
  logic              wr_control;
  logic              wr_period;
  logic              wr_length;
  logic              wr_direct;
  logic              wr_pattern;
  logic              pat_hit;
  logic [31:0]       addr_ext;
  logic [IdxW-1:0]   pat_idx;
  logic              running;
  logic              start_req;
  logic              stop_req;
  logic              tmr_clear;
  logic              tmr_zero;
  logic              seq_fire;
  logic              last_entry;
  logic              direct_issue;
  logic [DATA_W-1:0] direct_data;

  assign ctl_wr     = ctl_chipselect & ~ctl_write_n;
  assign addr_ext   = {28'b0, ctl_address};
  assign pat_hit    = (addr_ext >= 32'(AddrPattern)) && (addr_ext < 32'(AddrPattern) + DEPTH);
  assign pat_idx    = IdxW'(ctl_address - AddrPattern);

  assign wr_control = ctl_wr && (ctl_address == AddrControl);
  assign wr_period  = ctl_wr && (ctl_address == AddrPeriod);
  assign wr_length  = ctl_wr && (ctl_address == AddrLength);
  assign wr_direct  = ctl_wr && (ctl_address == AddrDirect);
  assign wr_pattern = ctl_wr && pat_hit;

  assign running    = (state_q == StRun);
  assign start_req  = wr_control && ctl_writedata[CtlRunBit] && !running && (length_q != '0);
  assign stop_req   = wr_control && !ctl_writedata[CtlRunBit] && running;
  assign tmr_clear  = start_req | stop_req;

  // A stop written in a strobe cycle wins, so no strobe follows the stop.
  assign seq_fire   = running && tmr_zero && !stop_req;
  assign last_entry = (LenW'(idx_q) + LenW'(1)) >= length_q;

  // A fresh write bypasses the buffer when nothing is pending; the latest data always wins.
  assign direct_issue = !seq_fire && (wr_direct || direct_pend_q);
  assign direct_data  = wr_direct ? ctl_writedata[DATA_W-1:0] : direct_buf_q;

  nios2mypio_seq_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .reload  (seq_fire),
    .step    (running),
    .period  (period_q),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      loop_q        <= 1'b0;
      period_q      <= '0;
      length_q      <= '0;
      direct_buf_q  <= '0;
      direct_pend_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pattern_q[i] <= '0;
      end
    end else begin
      if (wr_control) begin
        loop_q <= ctl_writedata[CtlLoopBit];
      end
      if (wr_period) begin
        period_q <= ctl_writedata[DIV_W-1:0];
      end
      if (wr_length) begin
        length_q <= LenW'(clamp_len(ctl_writedata, DEPTH));
      end
      if (wr_pattern) begin
        pattern_q[pat_idx] <= ctl_writedata[DATA_W-1:0];
      end
      if (wr_direct) begin
        direct_buf_q <= ctl_writedata[DATA_W-1:0];
      end
      direct_pend_q <= wr_direct ? seq_fire : (direct_pend_q && !direct_issue);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pio_cs_q   <= 1'b0;
      pio_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q   <= running;
      pio_cs_q <= seq_fire || direct_issue;
      if (seq_fire) begin
        pio_data_q <= pattern_q[idx_q];
      end else if (direct_issue) begin
        pio_data_q <= direct_data;
      end
      case (state_q)
        StIdle: begin
          if (start_req) begin
            state_q <= StRun;
            idx_q   <= '0;
          end
        end
        StRun: begin
          if (stop_req) begin
            state_q <= StIdle;
          end else if (seq_fire) begin
            if (!last_entry) begin
              idx_q <= idx_q + IdxW'(1);
            end else if (loop_q) begin
              idx_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ctl_readdata = '0;
    case (ctl_address)
      AddrControl: begin
        ctl_readdata[CtlRunBit]  = running;
        ctl_readdata[CtlLoopBit] = loop_q;
      end
      AddrStatus: begin
        ctl_readdata[StatRunBit]            = running;
        ctl_readdata[StatPendBit]           = direct_pend_q;
        ctl_readdata[StatIdxLsb +: IdxW]    = idx_q;
      end
      AddrPeriod: ctl_readdata[DIV_W-1:0] = period_q;
      AddrLength: ctl_readdata[LenW-1:0]  = length_q;
      default: begin
        if (pat_hit) begin
          ctl_readdata[DATA_W-1:0] = pattern_q[pat_idx];
        end
      end
    endcase
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = pio_cs_q;
  assign pio_write_n    = ~pio_cs_q;
  assign pio_writedata  = {{(32 - DATA_W){1'b0}}, pio_data_q};
  assign busy           = busy_q;

endmodule

// File: tb/tb_nios2mypio_pio_seq.sv
// Bench for the PIO pattern sequencer: expected PIO strobes (cycle, data) are queued as
// stimulus is issued and checked by a strobe monitor; register and status checks are inline.
module tb_nios2mypio_pio_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  ctl_address = '0;
  logic        ctl_chipselect = 1'b0;
  logic        ctl_write_n = 1'b1;
  logic [31:0] ctl_writedata = '0;
  logic [31:0] ctl_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } strobe_t;

  strobe_t exp_q[$];
  strobe_t mon_e;

  nios2mypio_pio_seq #(
    .DATA_W (7),
    .DEPTH  (8),
    .DIV_W  (24)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctl_address    (ctl_address),
    .ctl_chipselect (ctl_chipselect),
    .ctl_write_n    (ctl_write_n),
    .ctl_writedata  (ctl_writedata),
    .ctl_readdata   (ctl_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each PIO strobe pops the oldest expected strobe and must match its cycle and data.
  always @(negedge clk) begin
    if (pio_chipselect === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got data %h at cycle %0d, required no strobe",
                 pio_writedata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || pio_writedata !== mon_e.data || pio_write_n !== 1'b0 ||
            pio_address !== 2'b00) begin
          miscompares++;
          $display("FAIL strobe: got data %h cycle %0d wn %b addr %h, required data %h cycle %0d",
                   pio_writedata, cyc, pio_write_n, pio_address, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, output int n);
    ctl_address    = a;
    ctl_writedata  = d;
    ctl_chipselect = 1'b1;
    ctl_write_n    = 1'b0;
    n = cyc;
    @(posedge clk);
    #1;
    ctl_chipselect = 1'b0;
    ctl_write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    ctl_address    = a;
    ctl_chipselect = 1'b1;
    ctl_write_n    = 1'b1;
    #2;
    d = ctl_readdata;
    @(posedge clk);
    #1;
    ctl_chipselect = 1'b0;
  endtask

  task automatic push(input int c, input logic [31:0] d);
    strobe_t s;
    s.cyc  = c;
    s.data = d;
    exp_q.push_back(s);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [3:0]  addrs [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    vectors++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0 ||
        busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got cs %b wn %b data %h busy %b, required 0 1 0 0",
               pio_chipselect, pio_write_n, pio_writedata, busy);
    end
    for (int i = 0; i < 5; i++) begin
      bus_rd(addrs[i], rd);
      vectors++;
      if (rd !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg[%0d]: got %h required 0", addrs[i], rd);
      end
    end
  endtask

  task automatic test_single_shot();
    int n;
    logic [31:0] rd;
    bus_wr(4'd3, 32'd3, n);
    bus_wr(4'd8, 32'h3F, n);
    bus_wr(4'd9, 32'h06, n);
    bus_wr(4'd10, 32'h5B, n);
    bus_wr(4'd2, 32'd10, n);
    bus_wr(4'd0, 32'h1, n);
    push(n + 2, 32'h3F);
    push(n + 12, 32'h06);
    push(n + 22, 32'h5B);
    tick(21);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_at_last_strobe: got %b required 1", busy);
    end
    tick(1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_last_strobe: got %b required 0", busy);
    end
    bus_rd(4'd0, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL run_cleared: got %h required 0", rd);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_shot_strobes: got %0d missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_loop_stop();
    int n;
    int m;
    logic [31:0] rd;
    bus_wr(4'd3, 32'd2, n);
    bus_wr(4'd2, 32'd0, n);
    bus_wr(4'd0, 32'h3, n);
    push(n + 2, 32'h3F);
    push(n + 4, 32'h06);
    push(n + 6, 32'h3F);
    push(n + 8, 32'h06);
    tick(8);
    bus_wr(4'd0, 32'h0, m);
    tick(4);
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0 || pio_writedata !== 32'h06) begin
      miscompares++;
      $display("FAIL loop_stop: got missing %0d busy %b data %h, required 0 0 00000006",
               exp_q.size(), busy, pio_writedata);
    end
    bus_rd(4'd0, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL loop_stop_ctrl: got %h required 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int m;
    logic [31:0] rd;
    bus_wr(4'd2, 32'd6, n);
    bus_wr(4'd3, 32'd2, n);
    bus_wr(4'd0, 32'h1, n);
    push(n + 2, 32'h3F);
    push(n + 3, 32'h7F);
    push(n + 8, 32'h06);
    push(n + 9, 32'h02);
    bus_wr(4'd4, 32'h7F, m);
    bus_rd(4'd1, rd);
    vectors++;
    if (rd !== 32'h103) begin
      miscompares++;
      $display("FAIL status_pending: got %h required 00000103", rd);
    end
    tick(4);
    bus_wr(4'd4, 32'h01, m);
    bus_wr(4'd4, 32'h02, m);
    tick(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL direct_strobes: got %0d missing, required 0", exp_q.size());
    end
    bus_rd(4'd1, rd);
    vectors++;
    if (rd[1:0] !== 2'b00) begin
      miscompares++;
      $display("FAIL status_drained: got %b required 00", rd[1:0]);
    end
  endtask

  task automatic test_length_edges();
    int n;
    logic [31:0] rd;
    bus_wr(4'd3, 32'd0, n);
    bus_wr(4'd0, 32'h1, n);
    bus_rd(4'd0, rd);
    vectors++;
    if (rd !== 32'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL length_zero: got ctrl %h busy %b, required 0 0", rd, busy);
    end
    for (int i = 0; i < 8; i++) begin
      bus_wr(4'(8 + i), 32'(8'h40 + i), n);
    end
    bus_wr(4'd3, 32'd15, n);
    bus_wr(4'd2, 32'd2, n);
    bus_wr(4'd0, 32'h1, n);
    for (int i = 0; i < 8; i++) begin
      push(n + 2 + 2 * i, 32'(8'h40 + i));
    end
    tick(20);
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL length_clamp: got missing %0d busy %b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_live_update();
    int n;
    int m;
    bus_wr(4'd8, 32'h11, n);
    bus_wr(4'd9, 32'h22, n);
    bus_wr(4'd10, 32'h33, n);
    bus_wr(4'd3, 32'd3, n);
    bus_wr(4'd2, 32'd10, n);
    bus_wr(4'd0, 32'h1, n);
    push(n + 2, 32'h11);
    push(n + 12, 32'h55);
    push(n + 16, 32'h33);
    tick(4);
    bus_wr(4'd2, 32'd4, m);
    bus_wr(4'd9, 32'h55, m);
    tick(14);
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL live_update: got missing %0d busy %b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    logic [31:0] rd;
    logic [3:0]  addrs [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    bus_wr(4'd3, 32'd2, n);
    bus_wr(4'd2, 32'd3, n);
    bus_wr(4'd0, 32'h3, n);
    push(n + 2, 32'h11);
    tick(3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    vectors++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0 ||
        busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset_outputs: got cs %b wn %b data %h busy %b, required 0 1 0 0",
               pio_chipselect, pio_write_n, pio_writedata, busy);
    end
    tick(8);
    for (int i = 0; i < 5; i++) begin
      bus_rd(addrs[i], rd);
      vectors++;
      if (rd !== 32'h0) begin
        miscompares++;
        $display("FAIL midrun_reset_reg[%0d]: got %h required 0", addrs[i], rd);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL midrun_reset_strobes: got %0d missing, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_loop_stop();
    test_back_to_back();
    test_length_edges();
    test_live_update();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
